// File: rtl/mb_scan_gen.sv
// mb_scan_gen: raster-order 4x4 block coordinate sequencer feeding the
// intraloop stage. Emits {row, col} with valid/ready handshake, first/last
// markers, start/abort control and a one-cycle frame-done pulse.
module mb_scan_gen #(
   parameter int unsigned WIDTH  = 720,
   parameter int unsigned LENGTH = 1280,
   parameter int unsigned BLK    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        mb_ready,
   output logic        mb_valid,
   output logic [31:0] mbnumber,
   output logic        first_blk,
   output logic        last_blk,
   output logic        busy,
   output logic        frame_done,
   output logic [31:0] blk_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [15:0] COL_LAST = 16'(WIDTH - BLK);
   localparam logic [15:0] ROW_LAST = 16'(LENGTH - BLK);
   localparam logic [15:0] STEP     = 16'(BLK);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] row;
   logic [15:0] col;
   logic        xfer;
   logic        at_col_last;
   logic        at_last;
   logic        launch;

   // Handshake decode, next-state selection and output decodes.
   always_comb begin
      state_nxt   = state;
      xfer        = (state == S_RUN) && mb_ready;
      at_col_last = (col == COL_LAST);
      at_last     = at_col_last && (row == ROW_LAST);
      launch      = (state == S_IDLE) && start && !abort;
      mb_valid    = (state == S_RUN);
      busy        = (state == S_RUN);
      frame_done  = (state == S_DONE);
      mbnumber    = {row, col};
      first_blk   = mb_valid && (row == '0) && (col == '0);
      last_blk    = mb_valid && at_last;
      case (state)
         S_IDLE:  if (launch) state_nxt = S_RUN;
         S_RUN: begin
            if (abort)                state_nxt = S_IDLE;
            else if (xfer && at_last) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Coordinate stepping and transfer count; the final coordinate is held
   // after the last transfer rather than stepping past the frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row       <= '0;
         col       <= '0;
         blk_count <= '0;
      end else if (launch) begin
         row       <= '0;
         col       <= '0;
         blk_count <= '0;
      end else if (xfer) begin
         blk_count <= blk_count + 32'd1;
         if (!at_last) begin
            if (at_col_last) begin
               col <= '0;
               row <= row + STEP;
            end else begin
               col <= col + STEP;
            end
         end
      end
   end

endmodule

// File: tb/tb_mb_scan_gen.sv
// Self-checking bench for mb_scan_gen: a default-size instance for the full
// frame and a 16x8 instance for flow control, abort, reset and start cases.
module tb_mb_scan_gen;

   localparam int unsigned W0 = 720;
   localparam int unsigned L0 = 1280;
   localparam int unsigned W1 = 16;
   localparam int unsigned L1 = 8;
   localparam int unsigned B  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start0, abort0, rdy0;
   logic        v0, f0, l0, busy0, fd0;
   logic [31:0] mbn0, cnt0;
   logic        start1, abort1, rdy1;
   logic        v1, f1, l1, busy1, fd1;
   logic [31:0] mbn1, cnt1;

   mb_scan_gen dut0 (
      .clk(clk), .reset(reset), .start(start0), .abort(abort0),
      .mb_ready(rdy0), .mb_valid(v0), .mbnumber(mbn0), .first_blk(f0),
      .last_blk(l0), .busy(busy0), .frame_done(fd0), .blk_count(cnt0)
   );

   mb_scan_gen #(.WIDTH(W1), .LENGTH(L1), .BLK(B)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .abort(abort1),
      .mb_ready(rdy1), .mb_valid(v1), .mbnumber(mbn1), .first_blk(f1),
      .last_blk(l1), .busy(busy1), .frame_done(fd1), .blk_count(cnt1)
   );

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboards hold {first, last, mbnumber} per expected transfer.
   logic [33:0] q0[$];
   logic [33:0] q1[$];

   task automatic push_frame(input int unsigned w, input int unsigned l, input bit sel);
      logic [33:0] e;
      for (int unsigned r = 0; r < l / B; r++) begin
         for (int unsigned c = 0; c < w / B; c++) begin
            e[33]    = (r == 0) && (c == 0);
            e[32]    = (r == l / B - 1) && (c == w / B - 1);
            e[31:16] = 16'(r * B);
            e[15:0]  = 16'(c * B);
            if (sel) q1.push_back(e);
            else     q0.push_back(e);
         end
      end
   endtask

   int unsigned cyc = 0;
   int unsigned xfer0 = 0, fd_cnt0 = 0, last_cyc0 = 0, fd_cyc0 = 0;
   int unsigned xfer1 = 0, fd_cnt1 = 0, first_cyc1 = 0, last_cyc1 = 0;
   logic        stall1 = 1'b0;
   logic [31:0] held1  = '0;
   logic [33:0] e0, e1;

   // Monitor: pops the scoreboards on each handshake and checks stall hold.
   always @(negedge clk) begin
      cyc++;
      if (reset && v0 && rdy0) begin
         if (q0.size() == 0) check("q0_underflow", 1, 0);
         else begin
            e0 = q0.pop_front();
            check("mbn0", mbn0, e0[31:0]);
            check("first0", f0, e0[33]);
            check("last0", l0, e0[32]);
         end
         xfer0++;
         last_cyc0 = cyc;
      end
      if (fd0) begin
         fd_cnt0++;
         fd_cyc0 = cyc;
      end
      if (!reset) stall1 = 1'b0;
      else begin
         if (stall1) begin
            check("hold_mbn1", mbn1, held1);
            check("hold_v1", v1, 1);
         end
         stall1 = v1 && !rdy1;
         held1  = mbn1;
         if (v1 && rdy1) begin
            if (q1.size() == 0) check("q1_underflow", 1, 0);
            else begin
               e1 = q1.pop_front();
               check("mbn1", mbn1, e1[31:0]);
               check("first1", f1, e1[33]);
               check("last1", l1, e1[32]);
            end
            if (xfer1 == 0) first_cyc1 = cyc;
            xfer1++;
            last_cyc1 = cyc;
         end
      end
      if (fd1) fd_cnt1++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fd1(input string tag);
      bit seen = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (fd1) begin
            seen = 1;
            break;
         end
      end
      if (!seen) check(tag, 0, 1);
   endtask

   task automatic start_frame1();
      push_frame(W1, L1, 1'b1);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
   endtask

   initial begin
      bit seen;
      reset = 1'b0;
      start0 = 0; abort0 = 0; rdy0 = 0;
      start1 = 0; abort1 = 0; rdy1 = 0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_v", v0, 0);
      check("rst_mbn", mbn0, 0);
      check("rst_first", f0, 0);
      check("rst_last", l0, 0);
      check("rst_busy", busy0, 0);
      check("rst_fd", fd0, 0);
      check("rst_cnt", cnt0, 0);
      check("rst_mbn1", mbn1, 0);
      tick();
      reset = 1'b1;
      tick();

      // Full default frame at full throughput
      rdy0 = 1'b1;
      push_frame(W0, L0, 1'b0);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      check("t1_first_mbn", mbn0, 32'h0);
      check("t1_first_blk", f0, 1);
      check("t1_busy", busy0, 1);
      seen = 0;
      for (int i = 0; i < 60000; i++) begin
         @(negedge clk);
         if (fd0) begin
            seen = 1;
            break;
         end
      end
      if (!seen) check("t1_fd_timeout", 0, 1);
      check("t1_done_v", v0, 0);
      check("t1_done_busy", busy0, 0);
      check("t1_done_mbn", mbn0, 32'h04FC02CC);
      @(negedge clk);
      #1;
      check("t1_fd_drop", fd0, 0);
      check("t1_fd_once", fd_cnt0, 1);
      check("t1_fd_lat", fd_cyc0 - last_cyc0, 1);
      check("t1_xfers", xfer0, 57600);
      check("t1_cnt", cnt0, 57600);
      check("t1_q_empty", q0.size(), 0);
      rdy0 = 1'b0;
      tick();

      // Toggling ready on the small frame
      xfer1 = 0;
      fd_cnt1 = 0;
      rdy1 = 1'b1;
      start_frame1();
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (fd1) begin
            seen = 1;
            break;
         end
         rdy1 = ~rdy1;
      end
      if (!seen) check("t2_fd_timeout", 0, 1);
      check("t2_cnt", cnt1, 8);
      check("t2_xfers", xfer1, 8);
      check("t2_span", last_cyc1 - first_cyc1, 14);
      check("t2_q_empty", q1.size(), 0);
      rdy1 = 1'b0;
      tick();

      // Long stall after start
      start_frame1();
      for (int i = 0; i < 10; i++) begin
         check("t3_v", v1, 1);
         check("t3_mbn", mbn1, 0);
         check("t3_cnt", cnt1, 0);
         tick();
      end
      rdy1 = 1'b1;
      wait_fd1("t3_fd_timeout");
      check("t3_cnt_end", cnt1, 8);
      tick();

      // Abort concurrent with the third transfer
      fd_cnt1 = 0;
      start_frame1();
      tick();
      tick();
      abort1 = 1'b1;
      tick();
      abort1 = 1'b0;
      q1.delete();
      check("t4_v", v1, 0);
      check("t4_busy", busy1, 0);
      check("t4_cnt", cnt1, 3);
      for (int i = 0; i < 3; i++) begin
         check("t4_no_fd", fd1, 0);
         tick();
      end
      check("t4_fd_cnt", fd_cnt1, 0);
      start_frame1();
      check("t4_restart_mbn", mbn1, 0);
      check("t4_restart_first", f1, 1);
      wait_fd1("t4_fd_timeout");
      check("t4_cnt_end", cnt1, 8);
      tick();

      // Asynchronous reset mid-frame, then start+abort together
      start_frame1();
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      q1.delete();
      check("t5_v", v1, 0);
      check("t5_mbn", mbn1, 0);
      check("t5_busy", busy1, 0);
      check("t5_cnt", cnt1, 0);
      check("t5_first", f1, 0);
      check("t5_last", l1, 0);
      check("t5_fd", fd1, 0);
      tick();
      reset = 1'b1;
      tick();
      start1 = 1'b1;
      abort1 = 1'b1;
      tick();
      start1 = 1'b0;
      abort1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t5_idle_busy", busy1, 0);
         check("t5_idle_v", v1, 0);
         tick();
      end
      start_frame1();
      check("t5_restart_mbn", mbn1, 0);
      wait_fd1("t5_fd_timeout");
      check("t5_cnt_end", cnt1, 8);
      tick();

      // Start during RUN and during DONE is ignored
      fd_cnt1 = 0;
      start_frame1();
      tick();
      tick();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      wait_fd1("t6_fd_timeout");
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t6_idle_busy", busy1, 0);
         check("t6_idle_v", v1, 0);
         tick();
      end
      check("t6_cnt", cnt1, 8);
      check("t6_fd_cnt", fd_cnt1, 1);
      check("t6_q_empty", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mb_scan_gen.md
Name: mb_scan_gen

Overview:
- Upstream sequencer for the intra prediction loop.
- Generates the raster-order 4x4 block coordinate stream `mbnumber = {row, col}` that the intraloop stage consumes. One coordinate per accepted handshake.
- Adds start/abort control, valid/ready flow control, first/last markers and a frame-done pulse, replacing free-running address stepping in the frame pipeline.

Parameters:
- WIDTH, 720, frame width in pixels; multiple of BLK, max 65535.
- LENGTH, 1280, frame height in pixels; multiple of BLK, max 65535.
- BLK, 4, block edge in pixels; col and row step size.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin frame scan; sampled only in IDLE.
- abort  in  1  synchronous abort of current scan.
- mb_ready  in  1  downstream (intraloop) accepts the current coordinate.
- mb_valid  out  1  mbnumber holds a valid coordinate.
- mbnumber  out  32  {row[15:0], col[15:0]}, top-left pixel of the block.
- first_blk  out  1  high with the {0,0} coordinate.
- last_blk  out  1  high with the {LENGTH-BLK, WIDTH-BLK} coordinate.
- busy  out  1  high in RUN.
- frame_done  out  1  one-cycle pulse after the last block transfers.
- blk_count  out  32  number of transfers in the current or most recent frame.

Behaviour:
- Reset (reset=0, async): state IDLE; mb_valid=0, mbnumber=0, first_blk=0, last_blk=0, busy=0, frame_done=0, blk_count=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0 -> RUN next cycle.
  - On entry to RUN: mbnumber={0,0}, mb_valid=1, first_blk=1, busy=1, blk_count=0.
- RUN, transfer (mb_valid & mb_ready):
  - blk_count increments.
  - If col==WIDTH-BLK: col<=0, row<=row+BLK; otherwise col<=col+BLK.
  - The new coordinate is presented the cycle after the transfer. Latency 1; one transfer per cycle at full throughput.
- RUN, stall (mb_valid & !mb_ready): mbnumber, first_blk, last_blk held stable. mb_valid never drops without a transfer, except on abort or reset.
- Markers: first_blk and last_blk are combinational decodes of the presented coordinate, gated by mb_valid.
- Last block: transfer with row==LENGTH-BLK and col==WIDTH-BLK -> DONE.
  - Next cycle: mb_valid=0, busy=0, frame_done=1.
  - mbnumber holds the last coordinate.
- DONE: lasts one cycle, then IDLE. frame_done deasserts on leaving DONE.
- start while RUN or DONE: ignored.
- abort:
  - In RUN (with or without a concurrent transfer): next cycle IDLE, mb_valid=0, busy=0, no frame_done. blk_count keeps the transfers made, including one concurrent with abort.
  - In IDLE: overrides start.
  - In DONE: no effect.
- Arithmetic: row and col are 16-bit unsigned; they never exceed LENGTH-BLK and WIDTH-BLK, so no wrap occurs. blk_count is 32-bit.
- Full frame: (WIDTH/BLK)*(LENGTH/BLK) transfers; 57600 at defaults.
- Reset mid-frame: immediate return to the reset values above; the next frame begins at {0,0}.

Test Plan:
1. Defaults; reset low 3 cycles, then start pulse, mb_ready=1 constant -> first mbnumber 0x00000000 with first_blk=1; second 0x00000004; the 181st coordinate is 0x00040000. Last coordinate 0x04FC02CC with last_blk=1. blk_count=57600; frame_done pulses exactly once, 1 cycle after the last transfer.
2. WIDTH=16, LENGTH=8; mb_ready toggling 1/0 each cycle -> coordinates 0x00000000, 0x00000004, 0x00000008, 0x0000000C, 0x00040000 ... 0x0004000C, each held while mb_ready=0. 8 transfers total, in 16 cycles.
3. WIDTH=16, LENGTH=8; mb_ready=0 for 10 cycles after start -> mbnumber stays 0x00000000 and mb_valid stays 1 throughout; blk_count=0.
4. Abort asserted concurrently with the 3rd transfer -> mb_valid=0 next cycle, no frame_done, blk_count=3. A new start then restarts at 0x00000000.
5. reset driven low mid-frame between clock edges -> all outputs go to reset values immediately, without waiting for a clock edge. Start and abort asserted together in IDLE -> stays IDLE.
6. start asserted during RUN and during DONE -> no restart; frame completes with the normal count.
